uart_tx_param: RTL and testbench

//  Parametrised UART transmitter; successor to the lab single-frame TX.

---
 rtl/uart_tx_param_if.sv | 11 +
 rtl/uart_tx_param.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Producer-side valid/ready handshake carrying one TX word into uart_tx_param.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] TX_DATA;
  logic                 TX_VALID;
  logic                 TX_READY;

  modport master (output TX_DATA, output TX_VALID, input TX_READY);
  modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start/data/parity/stop framing, LSB first, back-to-back frames.
// Optional input FIFO enabled by defining UART_TX_FIFO_EN (default build: no FIFO).
module uart_tx_param #(
  parameter int unsigned CLK_FREQ   = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 2,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_param_if.slave tx_if,
  output logic           TXD,
  output logic           BUSY,
  output logic           FRAME_DONE
);

  localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW  = $clog2(DATA_BITS);

  // Elaboration-time parameter sanity checks
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;

  logic                 bit_end;
  logic                 stop_last;
  logic                 slot;
  logic                 push;
  logic                 word_avail;
  logic [DATA_BITS-1:0] word_data;
  logic                 word_take;

  assign bit_end   = (timer_q == TW'(DIV - 1));
  assign stop_last = (stop_q == 1'(STOP_BITS - 1));
  // FSM can start a new frame when idle or in the final cycle of the last stop bit
  assign slot      = (state_q == S_IDLE) || ((state_q == S_STOP) && bit_end && stop_last);
  assign push      = tx_if.TX_VALID & ready_q;
  assign word_take = slot & word_avail;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [AW:0]          cnt_q, cnt_d;

  assign word_avail = (cnt_q != '0);
  assign word_data  = mem_q[rd_q];

  // FIFO pointer and occupancy update
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push)      wr_d = wr_q + 1'b1;
    if (word_take) rd_d = rd_q + 1'b1;
    case ({push, word_take})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= tx_if.TX_DATA;
  end
`else
  assign word_avail = push;
  assign word_data  = tx_if.TX_DATA;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    txd_d   = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;

    case (state_q)
      S_IDLE: timer_d = '0;
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_last) state_d = S_IDLE;
          else           stop_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bit_end) timer_d = '0;

    if (word_take) begin
      state_d = S_START;
      timer_d = '0;
      shift_d = word_data;
      par_d   = (PARITY == 1) ? ~^word_data : ^word_data;
    end

    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (timer_d == TW'(DIV - 1)) && (stop_d == 1'(STOP_BITS - 1));
`ifdef UART_TX_FIFO_EN
    ready_d = (cnt_d != (AW + 1)'(FIFO_DEPTH));
`else
    ready_d = (state_d == S_IDLE) || done_d;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign TXD            = txd_q;
  assign BUSY           = busy_q;
  assign FRAME_DONE     = done_q;
  assign tx_if.TX_READY = ready_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: three line formats (8E1, 7O2, 5N1) at DIV=16,
// checked cycle by cycle against a frame-bit model; FIFO scenario when UART_TX_FIFO_EN is defined.
module tb_uart_tx_param;

  localparam int DIV = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       txd   [3];
  logic       busy  [3];
  logic       done  [3];
  logic       ready [3];
  logic       valid_v [3];
  logic [8:0] data_v  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(7)) if1 ();
  uart_tx_param_if #(.DATA_BITS(5)) if2 ();

  assign if0.TX_VALID = valid_v[0];
  assign if1.TX_VALID = valid_v[1];
  assign if2.TX_VALID = valid_v[2];
  assign if0.TX_DATA  = data_v[0][7:0];
  assign if1.TX_DATA  = data_v[1][6:0];
  assign if2.TX_DATA  = data_v[2][4:0];
  assign ready[0]     = if0.TX_READY;
  assign ready[1]     = if1.TX_READY;
  assign ready[2]     = if2.TX_READY;

  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8e1 (.CLK(CLK), .RST(RST), .tx_if(if0), .TXD(txd[0]), .BUSY(busy[0]), .FRAME_DONE(done[0]));
  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_7o2 (.CLK(CLK), .RST(RST), .tx_if(if1), .TXD(txd[1]), .BUSY(busy[1]), .FRAME_DONE(done[1]));
  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_5n1 (.CLK(CLK), .RST(RST), .tx_if(if2), .TXD(txd[2]), .BUSY(busy[2]), .FRAME_DONE(done[2]));

  function automatic int cfg_db(input int s);
    return (s == 0) ? 8 : (s == 1) ? 7 : 5;
  endfunction

  function automatic int cfg_par(input int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 0;
  endfunction

  function automatic int cfg_sb(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  function automatic int frame_cycles(input int s);
    return (1 + cfg_db(s) + ((cfg_par(s) != 0) ? 1 : 0) + cfg_sb(s)) * DIV;
  endfunction

  // Line level of bit k of a frame: start, data LSB first, optional parity, stop bits
  function automatic logic exp_bit(input int s, input logic [8:0] w, input int k);
    int   nd = cfg_db(s);
    logic p  = 1'b0;
    if (k == 0) return 1'b0;
    if (k <= nd) return w[4'(k - 1)];
    if ((cfg_par(s) != 0) && (k == nd + 1)) begin
      for (int j = 0; j < nd; j++) p = p ^ w[4'(j)];
      return (cfg_par(s) == 2) ? p : ~p;
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      valid_v[s] = 1'b0;
      data_v[s]  = '0;
    end
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (txd[s] !== 1'b1) begin n_fail++; $display("FAIL reset_txd[%0d]: got %b want 1", s, txd[s]); end
      n_checks++;
      if (busy[s] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy[s]); end
      n_checks++;
      if (done[s] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 0", s, done[s]); end
      n_checks++;
      if (ready[s] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 0", s, ready[s]); end
    end
    RST = 1'b0;
    @(negedge CLK);
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (ready[s] !== 1'b1) begin n_fail++; $display("FAIL release_ready[%0d]: got %b want 1", s, ready[s]); end
      n_checks++;
      if (busy[s] !== 1'b0) begin n_fail++; $display("FAIL release_busy[%0d]: got %b want 0", s, busy[s]); end
    end
  endtask

`ifndef UART_TX_FIFO_EN
  // Sends words with VALID held across frames; junk DATA/VALID while the line is busy
  task automatic test_stream(input int s, input string name, input logic [8:0] words[$]);
    int   n = frame_cycles(s);
    int   waited = 0;
    logic e_txd, e_last;
    @(negedge CLK);
    while ((ready[s] !== 1'b1) && (waited < 400)) begin
      @(negedge CLK);
      waited++;
    end
    n_checks++;
    if (ready[s] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: got %b want 1", name, ready[s]);
      return;
    end
    valid_v[s] = 1'b1;
    data_v[s]  = words[0];
    for (int f = 0; f < words.size(); f++) begin
      @(posedge CLK);
      for (int i = 0; i < n; i++) begin
        @(negedge CLK);
        e_txd  = exp_bit(s, words[f], i / DIV);
        e_last = (i == n - 1);
        n_checks++;
        if (txd[s] !== e_txd) begin
          n_fail++; $display("FAIL %s txd f%0d c%0d: got %b want %b", name, f, i, txd[s], e_txd);
        end
        n_checks++;
        if (busy[s] !== 1'b1) begin
          n_fail++; $display("FAIL %s busy f%0d c%0d: got %b want 1", name, f, i, busy[s]);
        end
        n_checks++;
        if (done[s] !== e_last) begin
          n_fail++; $display("FAIL %s frame_done f%0d c%0d: got %b want %b", name, f, i, done[s], e_last);
        end
        n_checks++;
        if (ready[s] !== e_last) begin
          n_fail++; $display("FAIL %s ready f%0d c%0d: got %b want %b", name, f, i, ready[s], e_last);
        end
        if (!e_last) begin
          valid_v[s] = 1'($urandom);
          data_v[s]  = 9'($urandom);
        end else if (f + 1 < words.size()) begin
          valid_v[s] = 1'b1;
          data_v[s]  = words[f + 1];
        end else begin
          valid_v[s] = 1'b0;
          data_v[s]  = 9'($urandom);
        end
      end
    end
    @(negedge CLK);
    n_checks++;
    if (busy[s] !== 1'b0) begin n_fail++; $display("FAIL %s idle_busy: got %b want 0", name, busy[s]); end
    n_checks++;
    if (txd[s] !== 1'b1) begin n_fail++; $display("FAIL %s idle_txd: got %b want 1", name, txd[s]); end
    n_checks++;
    if (ready[s] !== 1'b1) begin n_fail++; $display("FAIL %s idle_ready: got %b want 1", name, ready[s]); end
  endtask

  task automatic test_8e1();
    logic [8:0] q[$];
    q.push_back(9'h041);
    test_stream(0, "8e1_0x41", q);
  endtask

  task automatic test_7o2();
    logic [8:0] q[$];
    q.push_back(9'h000);
    test_stream(1, "7o2_0x00", q);
  endtask

  task automatic test_5n1();
    logic [8:0] q[$];
    q.push_back(9'h01F);
    test_stream(2, "5n1_0x1f", q);
  endtask

  task automatic test_back_to_back();
    logic [8:0] q[$];
    q.push_back(9'h055);
    q.push_back(9'h0AA);
    test_stream(0, "b2b_55_aa", q);
  endtask

  task automatic test_random();
    logic [8:0] q[$];
    for (int s = 0; s < 3; s++) begin
      q.delete();
      for (int k = 0; k < 3; k++) q.push_back(9'($urandom));
      test_stream(s, $sformatf("random_cfg%0d", s), q);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] w = 9'($urandom_range(0, 255));
    logic [8:0] q[$];
    logic       e_txd;
    @(negedge CLK);
    valid_v[0] = 1'b1;
    data_v[0]  = w;
    n_checks++;
    if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL midrst pre_ready: got %b want 1", ready[0]); end
    @(posedge CLK);
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      valid_v[0] = 1'b0;
      e_txd = exp_bit(0, w, i / DIV);
      n_checks++;
      if (txd[0] !== e_txd) begin n_fail++; $display("FAIL midrst txd c%0d: got %b want %b", i, txd[0], e_txd); end
    end
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (txd[0] !== 1'b1) begin n_fail++; $display("FAIL midrst txd: got %b want 1", txd[0]); end
    n_checks++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b want 0", busy[0]); end
    n_checks++;
    if (ready[0] !== 1'b0) begin n_fail++; $display("FAIL midrst ready: got %b want 0", ready[0]); end
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL midrst release_ready: got %b want 1", ready[0]); end
    n_checks++;
    if (txd[0] !== 1'b1) begin n_fail++; $display("FAIL midrst release_txd: got %b want 1", txd[0]); end
    q.push_back(9'h041);
    test_stream(0, "after_reset_0x41", q);
  endtask
`else
  // Six pushes into a 4-deep FIFO: the FSM drains one word immediately, so the sixth stalls
  // until the first frame's last stop cycle frees a slot
  task automatic test_fifo();
    logic [8:0] w[$];
    int   n = frame_cycles(0);
    int   total = 6 * n + 3;
    int   idx = 0;
    logic pushed;
    logic e_txd, e_busy, e_done;
    int   k;
    for (int j = 0; j < 6; j++) w.push_back(9'($urandom_range(0, 255)));
    @(negedge CLK);
    n_checks++;
    if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL fifo pre_ready: got %b want 1", ready[0]); end
    valid_v[0] = 1'b1;
    data_v[0]  = w[0];
    pushed     = 1'b1;
    for (int t = 0; t < total; t++) begin
      @(negedge CLK);
      if (pushed) begin
        idx++;
        if (idx < 6) data_v[0] = w[idx];
        else         valid_v[0] = 1'b0;
      end
      k      = t - 1;
      e_busy = (k >= 0) && (k < 6 * n);
      e_txd  = e_busy ? exp_bit(0, w[k / n], (k % n) / DIV) : 1'b1;
      e_done = e_busy && ((k % n) == n - 1);
      n_checks++;
      if (txd[0] !== e_txd) begin n_fail++; $display("FAIL fifo txd t%0d: got %b want %b", t, txd[0], e_txd); end
      n_checks++;
      if (busy[0] !== e_busy) begin n_fail++; $display("FAIL fifo busy t%0d: got %b want %b", t, busy[0], e_busy); end
      n_checks++;
      if (done[0] !== e_done) begin n_fail++; $display("FAIL fifo frame_done t%0d: got %b want %b", t, done[0], e_done); end
      if (t <= n + 1) begin
        n_checks++;
        if (ready[0] !== ((t <= 3) || (t == n + 1))) begin
          n_fail++; $display("FAIL fifo ready t%0d: got %b want %b", t, ready[0], ((t <= 3) || (t == n + 1)));
        end
      end
      pushed = valid_v[0] && ready[0];
    end
    n_checks++;
    if (idx != 6) begin n_fail++; $display("FAIL fifo accepted_words: got %0d want 6", idx); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef UART_TX_FIFO_EN
    test_8e1();
    test_7o2();
    test_back_to_back();
    test_5n1();
    test_random();
    test_reset_mid_frame();
`else
    test_fifo();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
